// File: rtl/alu_req_arbiter.sv
// -----------------------------------------------------------------------------
// alu_req_arbiter
//
// Shares one external combinational ALU between two requesters with
// round-robin arbitration. One request is accepted at a time. Its opcode is
// decoded and registered onto alu_op, and its operands onto alu_a and alu_b.
// One cycle later the ALU result is captured and returned on a single
// response channel, tagged with the requester id.
//
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   req0_* / req1_*               valid/ready request channels (opcode, a, b)
//   alu_op, alu_a, alu_b          registered ALU inputs; they hold when idle
//   alu_result                    combinational ALU result
//   rsp_valid/ready, rsp_id,      response channel; the result and flags are
//   rsp_result, rsp_illegal         held until the consumer takes them
//   illegal_count                 saturating count of accepted undefined opcodes
// -----------------------------------------------------------------------------
module alu_req_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [OP_WIDTH-1:0]   req0_opcode,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [OP_WIDTH-1:0]   req1_opcode,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,

  output logic [3:0]            alu_op,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_result,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_illegal,
  output logic [7:0]            illegal_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   prio;       // 0: req0 wins a tie, 1: req1 wins a tie
  logic   id_q;       // id of the op currently in the ALU
  logic   illegal_q;  // decode flag of the op currently in the ALU

  logic                  grant;
  logic                  accept;
  logic [OP_WIDTH-1:0]   sel_opcode;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;
  logic [3:0]            dec_op;
  logic                  dec_illegal;

  // Grant selection and opcode decode of the granted request.
  always_comb begin
    // NOTE: every signal gets a default first so that no path through this
    // block leaves it unassigned, which would otherwise infer a latch.
    grant       = 1'b0;
    dec_op      = 4'd0;
    dec_illegal = 1'b1;

    if (req0_valid && req1_valid) begin
      grant = prio;
    end else if (req1_valid) begin
      grant = 1'b1;
    end

    accept     = (state == IDLE) && (req0_valid || req1_valid);
    sel_opcode = grant ? req1_opcode : req0_opcode;
    sel_a      = grant ? req1_a      : req0_a;
    sel_b      = grant ? req1_b      : req0_b;

    // Opcodes 0..5 map one-to-one onto ALU codes; anything else runs as ADD.
    if (sel_opcode <= OP_WIDTH'(5)) begin
      dec_op      = 4'(sel_opcode);
      dec_illegal = 1'b0;
    end
  end

  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid &&  grant;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so that every
    // register samples the values from before this edge, whatever the order
    // of the statements.
    if (rst) begin
      state         <= IDLE;
      prio          <= 1'b0;
      id_q          <= 1'b0;
      illegal_q     <= 1'b0;
      alu_op        <= 4'd0;
      alu_a         <= '0;
      alu_b         <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_result    <= '0;
      rsp_illegal   <= 1'b0;
      illegal_count <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          // alu_* are written only on acceptance, so the ALU inputs stay
          // quiet while nothing is requested.
          if (accept) begin
            alu_op    <= dec_op;
            alu_a     <= sel_a;
            alu_b     <= sel_b;
            id_q      <= grant;
            illegal_q <= dec_illegal;
            prio      <= ~grant;
            if (dec_illegal && (illegal_count != 8'hFF)) begin
              illegal_count <= illegal_count + 8'd1;
            end
            state <= EXEC;
          end
        end

        EXEC: begin
          rsp_result  <= alu_result;
          rsp_id      <= id_q;
          rsp_illegal <= illegal_q;
          rsp_valid   <= 1'b1;
          state       <= RESP;
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_req_arbiter
//
// Self-checking bench for alu_req_arbiter. A small combinational ALU model
// drives alu_result from the DUT's registered ALU inputs. Directed scenarios
// cover reset, basic operation, round-robin, illegal opcodes with saturation,
// back-pressure, reset during EXEC and idle hold. A randomized run is checked
// against a transaction-level reference model: grants, response timing and
// response contents are predicted from the requests alone.
// -----------------------------------------------------------------------------
module tb_alu_req_arbiter;

  localparam int DW = 8;
  localparam int OW = 4;

  logic          clk;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [OW-1:0] req0_opcode, req1_opcode;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]    alu_op;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_illegal;
  logic [DW-1:0] rsp_result;
  logic [7:0]    illegal_count;

  int pass_count  = 0;
  int check_count = 0;

  typedef struct packed {
    logic [3:0] opc;
    logic [7:0] a;
    logic [7:0] b;
  } op_t;

  alu_req_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_illegal(rsp_illegal),
    .illegal_count(illegal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: shifts use the low three bits of operand B.
  always_comb begin
    case (alu_op)
      4'd0:    alu_result = alu_a + alu_b;
      4'd1:    alu_result = alu_a - alu_b;
      4'd2:    alu_result = alu_a | alu_b;
      4'd3:    alu_result = alu_a & alu_b;
      4'd4:    alu_result = alu_a << alu_b[2:0];
      4'd5:    alu_result = alu_a >> alu_b[2:0];
      default: alu_result = 8'h00;
    endcase
  end

  // Expected result of a request, straight from its opcode (undefined -> ADD).
  function automatic logic [7:0] ref_result(input op_t op);
    case (op.opc)
      4'd1:    return op.a - op.b;
      4'd2:    return op.a | op.b;
      4'd3:    return op.a & op.b;
      4'd4:    return op.a << op.b[2:0];
      4'd5:    return op.a >> op.b[2:0];
      default: return op.a + op.b;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_opcode = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_opcode = '0; req1_a = '0; req1_b = '0;
    rsp_ready  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    check_count++; if (alu_op !== 4'd0) $display("FAIL reset_alu_op got=%0h exp=0", alu_op); else pass_count++;
    check_count++; if (alu_a !== 8'h00) $display("FAIL reset_alu_a got=%0h exp=0", alu_a); else pass_count++;
    check_count++; if (alu_b !== 8'h00) $display("FAIL reset_alu_b got=%0h exp=0", alu_b); else pass_count++;
    check_count++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); else pass_count++;
    check_count++; if (rsp_result !== 8'h00) $display("FAIL reset_rsp_result got=%0h exp=0", rsp_result); else pass_count++;
    check_count++; if (rsp_id !== 1'b0) $display("FAIL reset_rsp_id got=%0b exp=0", rsp_id); else pass_count++;
    check_count++; if (rsp_illegal !== 1'b0) $display("FAIL reset_rsp_illegal got=%0b exp=0", rsp_illegal); else pass_count++;
    check_count++; if (illegal_count !== 8'd0) $display("FAIL reset_illegal_count got=%0d exp=0", illegal_count); else pass_count++;
    check_count++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL reset_readies got=%b exp=00", {req0_ready, req1_ready}); else pass_count++;
  endtask

  task automatic test_add_basic();
    do_reset();
    req0_valid = 1'b1; req0_opcode = 4'd0; req0_a = 8'h12; req0_b = 8'h34;
    #1;
    check_count++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL add_readies got=%b exp=10", {req0_ready, req1_ready}); else pass_count++;
    tick();
    req0_valid = 1'b0;
    check_count++; if (alu_op !== 4'd0) $display("FAIL add_alu_op got=%0h exp=0", alu_op); else pass_count++;
    check_count++; if (alu_a !== 8'h12) $display("FAIL add_alu_a got=%0h exp=12", alu_a); else pass_count++;
    check_count++; if (alu_b !== 8'h34) $display("FAIL add_alu_b got=%0h exp=34", alu_b); else pass_count++;
    check_count++; if (rsp_valid !== 1'b0) $display("FAIL add_exec_rsp_valid got=%0b exp=0", rsp_valid); else pass_count++;
    tick();
    check_count++; if (rsp_valid !== 1'b1) $display("FAIL add_rsp_valid got=%0b exp=1", rsp_valid); else pass_count++;
    check_count++; if (rsp_result !== 8'h46) $display("FAIL add_rsp_result got=%0h exp=46", rsp_result); else pass_count++;
    check_count++; if (rsp_id !== 1'b0) $display("FAIL add_rsp_id got=%0b exp=0", rsp_id); else pass_count++;
    check_count++; if (rsp_illegal !== 1'b0) $display("FAIL add_rsp_illegal got=%0b exp=0", rsp_illegal); else pass_count++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_count++; if (rsp_valid !== 1'b0) $display("FAIL add_rsp_taken got=%0b exp=0", rsp_valid); else pass_count++;
  endtask

  task automatic test_round_robin();
    int         acc_id[$];
    int         acc_cyc[$];
    int         rsp_ids[$];
    logic [7:0] rsp_res[$];
    do_reset();
    rsp_ready  = 1'b1;
    req0_valid = 1'b1; req0_opcode = 4'd1; req0_a = 8'h50; req0_b = 8'h10;
    req1_valid = 1'b1; req1_opcode = 4'd3; req1_a = 8'hF0; req1_b = 8'h3C;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (req0_ready) begin acc_id.push_back(0); acc_cyc.push_back(c); end
      if (req1_ready) begin acc_id.push_back(1); acc_cyc.push_back(c); end
      if (rsp_valid) begin rsp_ids.push_back(int'(rsp_id)); rsp_res.push_back(rsp_result); end
      tick();
    end
    idle_inputs();
    check_count++; if (acc_id.size() != 4) $display("FAIL rr_grant_count got=%0d exp=4", acc_id.size()); else pass_count++;
    check_count++; if (rsp_ids.size() != 4) $display("FAIL rr_rsp_count got=%0d exp=4", rsp_ids.size()); else pass_count++;
    for (int i = 0; i < 4; i++) begin
      if (i < acc_id.size()) begin
        check_count++; if (acc_id[i] != i % 2) $display("FAIL rr_grant_id[%0d] got=%0d exp=%0d", i, acc_id[i], i % 2); else pass_count++;
        check_count++; if (acc_cyc[i] != 3 * i) $display("FAIL rr_grant_cycle[%0d] got=%0d exp=%0d", i, acc_cyc[i], 3 * i); else pass_count++;
      end
      if (i < rsp_ids.size()) begin
        check_count++; if (rsp_ids[i] != i % 2) $display("FAIL rr_rsp_id[%0d] got=%0d exp=%0d", i, rsp_ids[i], i % 2); else pass_count++;
        check_count++;
        if (rsp_res[i] !== ((i % 2 == 0) ? 8'h40 : 8'h30))
          $display("FAIL rr_rsp_result[%0d] got=%0h exp=%0h", i, rsp_res[i], (i % 2 == 0) ? 8'h40 : 8'h30);
        else pass_count++;
      end
    end
  endtask

  task automatic test_illegal();
    int accepts = 0;
    do_reset();
    req1_valid = 1'b1; req1_opcode = 4'b1010; req1_a = 8'h01; req1_b = 8'h02;
    #1;
    check_count++; if ({req0_ready, req1_ready} !== 2'b01) $display("FAIL ill_readies got=%b exp=01", {req0_ready, req1_ready}); else pass_count++;
    tick();
    req1_valid = 1'b0;
    check_count++; if (alu_op !== 4'd0) $display("FAIL ill_alu_op got=%0h exp=0", alu_op); else pass_count++;
    check_count++; if (illegal_count !== 8'd1) $display("FAIL ill_count_first got=%0d exp=1", illegal_count); else pass_count++;
    tick();
    check_count++; if (rsp_result !== 8'h03) $display("FAIL ill_rsp_result got=%0h exp=03", rsp_result); else pass_count++;
    check_count++; if (rsp_illegal !== 1'b1) $display("FAIL ill_rsp_illegal got=%0b exp=1", rsp_illegal); else pass_count++;
    check_count++; if (rsp_id !== 1'b1) $display("FAIL ill_rsp_id got=%0b exp=1", rsp_id); else pass_count++;
    rsp_ready = 1'b1;
    tick();
    // 259 more illegal ops, one every 3 cycles, for 260 in total.
    req1_valid = 1'b1;
    for (int c = 0; c < 777; c++) begin
      #1;
      if (req1_ready) accepts++;
      tick();
    end
    req1_valid = 1'b0;
    check_count++; if (accepts != 259) $display("FAIL ill_accepts got=%0d exp=259", accepts); else pass_count++;
    check_count++; if (illegal_count !== 8'd255) $display("FAIL ill_count_saturated got=%0d exp=255", illegal_count); else pass_count++;
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req0_valid = 1'b1; req0_opcode = 4'd4; req0_a = 8'h81; req0_b = 8'h01;
    #1;
    check_count++; if (req0_ready !== 1'b1) $display("FAIL bp_req0_ready got=%0b exp=1", req0_ready); else pass_count++;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_opcode = 4'd3; req1_a = 8'hFF; req1_b = 8'h0F;
    #1;
    check_count++; if (req1_ready !== 1'b0) $display("FAIL bp_exec_req1_ready got=%0b exp=0", req1_ready); else pass_count++;
    tick();
    for (int k = 0; k < 5; k++) begin
      check_count++; if (rsp_valid !== 1'b1) $display("FAIL bp_hold_valid[%0d] got=%0b exp=1", k, rsp_valid); else pass_count++;
      check_count++; if (rsp_result !== 8'h02) $display("FAIL bp_hold_result[%0d] got=%0h exp=02", k, rsp_result); else pass_count++;
      check_count++; if (rsp_id !== 1'b0) $display("FAIL bp_hold_id[%0d] got=%0b exp=0", k, rsp_id); else pass_count++;
      check_count++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL bp_hold_readies[%0d] got=%b exp=00", k, {req0_ready, req1_ready}); else pass_count++;
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check_count++; if (req1_ready !== 1'b0) $display("FAIL bp_handshake_req1_ready got=%0b exp=0", req1_ready); else pass_count++;
    tick();
    check_count++; if (rsp_valid !== 1'b0) $display("FAIL bp_taken_valid got=%0b exp=0", rsp_valid); else pass_count++;
    check_count++; if (req1_ready !== 1'b1) $display("FAIL bp_after_req1_ready got=%0b exp=1", req1_ready); else pass_count++;
    tick();
    req1_valid = 1'b0;
    tick();
    check_count++; if (rsp_valid !== 1'b1) $display("FAIL bp_second_valid got=%0b exp=1", rsp_valid); else pass_count++;
    check_count++; if (rsp_result !== 8'h0F) $display("FAIL bp_second_result got=%0h exp=0f", rsp_result); else pass_count++;
    check_count++; if (rsp_id !== 1'b1) $display("FAIL bp_second_id got=%0b exp=1", rsp_id); else pass_count++;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_exec();
    do_reset();
    req0_valid = 1'b1; req0_opcode = 4'hC; req0_a = 8'h33; req0_b = 8'h44;
    tick();
    req0_valid = 1'b0;
    check_count++; if (illegal_count !== 8'd1) $display("FAIL rst_exec_pre_count got=%0d exp=1", illegal_count); else pass_count++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_count++; if (rsp_valid !== 1'b0) $display("FAIL rst_exec_rsp_valid got=%0b exp=0", rsp_valid); else pass_count++;
    check_count++; if ({alu_op, alu_a, alu_b} !== 20'h0) $display("FAIL rst_exec_alu got=%0h exp=0", {alu_op, alu_a, alu_b}); else pass_count++;
    check_count++; if ({rsp_id, rsp_illegal, rsp_result} !== 10'h0) $display("FAIL rst_exec_rsp got=%0h exp=0", {rsp_id, rsp_illegal, rsp_result}); else pass_count++;
    check_count++; if (illegal_count !== 8'd0) $display("FAIL rst_exec_count got=%0d exp=0", illegal_count); else pass_count++;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check_count++; if (rsp_valid !== 1'b0) $display("FAIL rst_exec_no_rsp[%0d] got=%0b exp=0", k, rsp_valid); else pass_count++;
      tick();
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check_count++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL rst_exec_grant got=%b exp=10", {req0_ready, req1_ready}); else pass_count++;
    idle_inputs();
  endtask

  task automatic test_idle_hold();
    do_reset();
    rsp_ready  = 1'b1;
    req0_valid = 1'b1; req0_opcode = 4'd2; req0_a = 8'hA5; req0_b = 8'h0F;
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 10; k++) begin
      req0_opcode = 4'($urandom); req0_a = 8'($urandom); req0_b = 8'($urandom);
      req1_opcode = 4'($urandom); req1_a = 8'($urandom); req1_b = 8'($urandom);
      #1;
      check_count++;
      if ({alu_op, alu_a, alu_b} !== {4'd2, 8'hA5, 8'h0F})
        $display("FAIL idle_hold_alu[%0d] got=%0h exp=2a50f", k, {alu_op, alu_a, alu_b});
      else pass_count++;
      check_count++; if (rsp_valid !== 1'b0) $display("FAIL idle_hold_rsp_valid[%0d] got=%0b exp=0", k, rsp_valid); else pass_count++;
      check_count++; if (rsp_result !== 8'hAF) $display("FAIL idle_hold_rsp_result[%0d] got=%0h exp=af", k, rsp_result); else pass_count++;
      tick();
    end
    idle_inputs();
  endtask

  // Randomized traffic against a transaction-level model: an op accepted in
  // cycle c is answered from cycle c+2 until taken, and no request is granted
  // from cycle c+1 until the response is taken.
  task automatic test_random();
    op_t q0[$];
    op_t q1[$];
    op_t fl_op;
    bit  inflight = 1'b0;
    bit  fl_id    = 1'b0;
    bit  favour   = 1'b0;
    int  acc_cyc  = 0;
    int  exp_ill  = 0;
    int  served   = 0;
    bit  v0, v1, e0, e1, rsp_due;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      q0.push_back('{opc: 4'($urandom_range(0, 15)), a: 8'($urandom), b: 8'($urandom)});
      q1.push_back('{opc: 4'($urandom_range(0, 15)), a: 8'($urandom), b: 8'($urandom)});
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      v0 = (q0.size() > 0) && ($urandom_range(0, 3) != 0);
      v1 = (q1.size() > 0) && ($urandom_range(0, 3) != 0);
      req0_valid = v0;
      req1_valid = v1;
      if (q0.size() > 0) {req0_opcode, req0_a, req0_b} = q0[0];
      else {req0_opcode, req0_a, req0_b} = 20'($urandom);
      if (q1.size() > 0) {req1_opcode, req1_a, req1_b} = q1[0];
      else {req1_opcode, req1_a, req1_b} = 20'($urandom);
      rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      e0 = !inflight && v0 && (!v1 || !favour);
      e1 = !inflight && v1 && (!v0 || favour);
      rsp_due = inflight && (cyc >= acc_cyc + 2);
      check_count++; if ({req0_ready, req1_ready} !== {e0, e1}) $display("FAIL rand_readies cyc=%0d got=%b exp=%b", cyc, {req0_ready, req1_ready}, {e0, e1}); else pass_count++;
      check_count++; if (rsp_valid !== rsp_due) $display("FAIL rand_rsp_valid cyc=%0d got=%0b exp=%0b", cyc, rsp_valid, rsp_due); else pass_count++;
      if (rsp_due && rsp_ready) begin
        check_count++; if (rsp_id !== fl_id) $display("FAIL rand_rsp_id cyc=%0d got=%0b exp=%0b", cyc, rsp_id, fl_id); else pass_count++;
        check_count++; if (rsp_result !== ref_result(fl_op)) $display("FAIL rand_rsp_result cyc=%0d got=%0h exp=%0h", cyc, rsp_result, ref_result(fl_op)); else pass_count++;
        check_count++; if (rsp_illegal !== (fl_op.opc > 4'd5)) $display("FAIL rand_rsp_illegal cyc=%0d got=%0b exp=%0b", cyc, rsp_illegal, fl_op.opc > 4'd5); else pass_count++;
        inflight = 1'b0;
        served++;
      end
      if (e0 || e1) begin
        fl_op    = e1 ? q1.pop_front() : q0.pop_front();
        fl_id    = e1;
        favour   = !e1;
        inflight = 1'b1;
        acc_cyc  = cyc;
        if (fl_op.opc > 4'd5 && exp_ill < 255) exp_ill++;
      end
      tick();
    end
    check_count++; if (illegal_count !== 8'(exp_ill)) $display("FAIL rand_illegal_count got=%0d exp=%0d", illegal_count, exp_ill); else pass_count++;
    check_count++; if (served < 20) $display("FAIL rand_served got=%0d exp=at least 20", served); else pass_count++;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_add_basic();
    test_round_robin();
    test_illegal();
    test_backpressure();
    test_reset_mid_exec();
    test_idle_hold();
    test_random();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
